lfsr_window_counter_ctrl: RTL
=============================

Name: lfsr_window_counter_ctrl

Overview:
Measurement-window controller for one 6-bit state-extension LFSR counter stage.
- Clears the attached stage, then gates its count enable with an event input for a programmed number of clocks.
- Extends range by counting the stage's wrap pulses in a binary overflow register.
- Captures the raw LFSR state and presents the result on a valid/ready port.
- Sits between the counter stage and the measurement/readout logic.

Parameters:
EXT_W, 10, width of binary overflow (wrap-pulse) counter
WIN_W, 16, width of window-length input and window timer
DRAIN_CYC, 2, idle cycles after window close before capture; min 1

Ports:
Clk  in  1  clock, all state on rising edge
Rst  in  1  reset, synchronous, active-high
Start  in  1  request new measurement; sampled in IDLE only
Abort  in  1  cancel measurement in progress
Win_Len  in  WIN_W  window length in clocks; latched on accepted Start
Evt  in  1  event qualifier; one count per clock while high inside window
Busy  out  1  high in every state except IDLE
Cnt_En  out  1  count enable to counter stage
Ctr_Clr_n  out  1  counter clear, active-low
Ctr_Q  in  6  counter stage state output
Ctr_Next  in  1  counter wrap pulse, one clock wide per 64 counts
Res_Valid  out  1  result available
Res_Ready  in  1  consumer accepts result
Res_Ovf  out  EXT_W  wrap-pulse count for the window
Res_Lfsr  out  6  captured Ctr_Q
Res_Ovf_Flag  out  1  overflow-counter saturation flag (see Optional Feature)

Behaviour:
- Reset (Rst=1 at edge): state IDLE. Busy=0, Cnt_En=0, Ctr_Clr_n=1, Res_Valid=0, Res_Ovf=0, Res_Lfsr=0, Res_Ovf_Flag=0, window timer=0. Reset in any state, including mid-RUN, takes effect at that edge.
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE -> CLEAR when Start=1.
  - Latch Win_Len.
  - Start in any other state is ignored.
- CLEAR: exactly 1 cycle.
  - Ctr_Clr_n=0, Cnt_En=0.
  - Overflow counter and flag cleared.
  - Next state is RUN, or DRAIN if the latched Win_Len=0.
- RUN: exactly Win_Len cycles.
  - Cnt_En=Evt, registered-free combinational pass, gated by state.
  - Timer decrements each cycle; on the cycle timer==1, go to DRAIN.
- DRAIN: DRAIN_CYC cycles with Cnt_En=0, Ctr_Clr_n=1. This lets the last wrap pulse arrive.
- Ctr_Next=1 in RUN or DRAIN increments the overflow counter by 1. Ctr_Next is ignored in all other states.
- DRAIN -> DONE: Res_Lfsr<=Ctr_Q, Res_Ovf<=overflow counter, Res_Valid<=1.
- DONE:
  - Outputs held stable while Res_Valid=1 and Res_Ready=0.
  - Res_Valid=1 and Res_Ready=1 at an edge completes the transfer: Res_Valid<=0, go to IDLE.
  - Res_Ovf and Res_Lfsr keep their last values until the next capture.
- Abort=1 in CLEAR, RUN or DRAIN: next state IDLE, Cnt_En=0, no result produced.
  - Ctr_Clr_n=0 for that one transition cycle.
  - Abort in DONE or IDLE is ignored.
- Abort has priority over timer expiry. Rst has priority over everything.
- Latency from Start to Res_Valid: 1 (CLEAR) + Win_Len + DRAIN_CYC + 1 clocks.
- Overflow counter wraps modulo 2^EXT_W by default.
- Total events in window = 64*Res_Ovf + position of Res_Lfsr in the counter sequence. Decode is done downstream, not in this block.

Optional Feature:
Macro LFSR_OVF_SAT_EN.
- Defined: the overflow counter saturates at 2^EXT_W-1. Any further Ctr_Next sets a sticky flag, which is cleared in CLEAR and copied to Res_Ovf_Flag at capture.
- Undefined: the counter wraps and Res_Ovf_Flag is tied to 0.

Test Plan:
- Win_Len=5, Evt=1 continuously -> Cnt_En high exactly 5 cycles; Res_Ovf=0; Res_Lfsr equals counter state after 5 steps from clear; Res_Valid at clock 1+5+2+1=9 after Start.
- Win_Len=130, Evt=1 -> two Ctr_Next pulses; Res_Ovf=2; Res_Lfsr equals state after 2 counts.
- Win_Len=20, Evt alternating 1/0 starting at 1 -> 10 counts enabled; Res_Ovf=0; Start pulses during RUN ignored (Busy stays 1, latched length unchanged).
- Result ready, Res_Ready=0 for 10 cycles then 1 -> Res_Valid, Res_Ovf, Res_Lfsr stable for all 10 cycles; IDLE one cycle after handshake; Win_Len=0 run -> Res_Ovf=0, Res_Lfsr=cleared state.
- Abort at RUN cycle 7, then Rst=1 at RUN cycle 3 of a new run -> each returns to IDLE next edge; no Res_Valid; Ctr_Clr_n low one cycle on abort; all outputs at reset values after Rst.
- EXT_W=2, Win_Len=320, Evt=1 -> 5 wraps; without LFSR_OVF_SAT_EN: Res_Ovf=1, flag=0; with it: Res_Ovf=3, Res_Ovf_Flag=1.

Source files
------------

// File: rtl/lfsr_window_counter_ctrl_if.sv
// Result port of the LFSR measurement-window controller: a valid/ready handshake
// carrying the captured wrap count, the raw LFSR state and the saturation flag.
interface lfsr_window_counter_ctrl_if #(
  parameter int EXT_W = 10
) ();
  logic             Res_Valid;
  logic             Res_Ready;
  logic [EXT_W-1:0] Res_Ovf;
  logic [5:0]       Res_Lfsr;
  logic             Res_Ovf_Flag;

  modport master (
    output Res_Valid,
    output Res_Ovf,
    output Res_Lfsr,
    output Res_Ovf_Flag,
    input  Res_Ready
  );

  modport slave (
    input  Res_Valid,
    input  Res_Ovf,
    input  Res_Lfsr,
    input  Res_Ovf_Flag,
    output Res_Ready
  );
endinterface

// File: rtl/lfsr_window_counter_ctrl.sv
// Measurement-window controller for a 6-bit state-extension LFSR counter stage.
// Optional macro LFSR_OVF_SAT_EN: saturating overflow counter with sticky flag.
module lfsr_window_counter_ctrl #(
  parameter int EXT_W     = 10,
  parameter int WIN_W     = 16,
  parameter int DRAIN_CYC = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic [WIN_W-1:0]      Win_Len,
  input  logic                  Evt,
  output logic                  Busy,
  output logic                  Cnt_En,
  output logic                  Ctr_Clr_n,
  input  logic [5:0]            Ctr_Q,
  input  logic                  Ctr_Next,
  lfsr_window_counter_ctrl_if.master res
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_CYC - 1);
  localparam logic [DW-1:0]    DRAIN_ONE  = DW'(1);
  localparam logic [DW-1:0]    DRAIN_ZERO = DW'(0);
  localparam logic [WIN_W-1:0] WIN_ONE    = WIN_W'(1);
  localparam logic [WIN_W-1:0] WIN_ZERO   = WIN_W'(0);
  localparam logic [EXT_W-1:0] OVF_ZERO   = EXT_W'(0);
  localparam logic [EXT_W-1:0] OVF_ONE    = EXT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_r;
  logic             busy_r;
  logic             clr_n_r;
  logic [WIN_W-1:0] timer_r;
  logic [DW-1:0]    drain_r;
  logic [EXT_W-1:0] ovf_r;
  logic             ovf_inc_s;
  logic [EXT_W-1:0] ovf_next_s;
  logic             flag_next_s;
  logic             cnt_en_s;
`ifdef LFSR_OVF_SAT_EN
  localparam logic [EXT_W-1:0] OVF_MAX = {EXT_W{1'b1}};
  logic             flag_r;
`endif

  assign Busy      = busy_r;
  assign Ctr_Clr_n = clr_n_r;
  assign Cnt_En    = cnt_en_s;

  // Count enable: the event qualifier passes straight through while a window is open.
  always_comb begin
    if ((state_r == ST_RUN) && !Abort) begin
      cnt_en_s = Evt;
    end else begin
      cnt_en_s = 1'b0;
    end
  end

  // Next value of the wrap-pulse counter; wrap pulses only count in RUN and DRAIN.
  always_comb begin
    if (((state_r == ST_RUN) || (state_r == ST_DRAIN)) && Ctr_Next) begin
      ovf_inc_s = 1'b1;
    end else begin
      ovf_inc_s = 1'b0;
    end
`ifdef LFSR_OVF_SAT_EN
    if (ovf_inc_s && (ovf_r == OVF_MAX)) begin
      ovf_next_s  = ovf_r;
      flag_next_s = 1'b1;
    end else if (ovf_inc_s) begin
      ovf_next_s  = ovf_r + OVF_ONE;
      flag_next_s = flag_r;
    end else begin
      ovf_next_s  = ovf_r;
      flag_next_s = flag_r;
    end
`else
    if (ovf_inc_s) begin
      ovf_next_s = ovf_r + OVF_ONE;
    end else begin
      ovf_next_s = ovf_r;
    end
    flag_next_s = 1'b0;
`endif
  end

  // Window FSM with registered status, clear and result outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r          <= ST_IDLE;
      busy_r           <= 1'b0;
      clr_n_r          <= 1'b1;
      timer_r          <= WIN_ZERO;
      drain_r          <= DRAIN_ZERO;
      ovf_r            <= OVF_ZERO;
`ifdef LFSR_OVF_SAT_EN
      flag_r           <= 1'b0;
`endif
      res.Res_Valid    <= 1'b0;
      res.Res_Ovf      <= OVF_ZERO;
      res.Res_Lfsr     <= 6'd0;
      res.Res_Ovf_Flag <= 1'b0;
    end else begin
      clr_n_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            state_r <= ST_CLEAR;
            busy_r  <= 1'b1;
            clr_n_r <= 1'b0;
            timer_r <= Win_Len;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          ovf_r  <= OVF_ZERO;
`ifdef LFSR_OVF_SAT_EN
          flag_r <= 1'b0;
`endif
          if (Abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            clr_n_r <= 1'b0;
          end else if (timer_r == WIN_ZERO) begin
            state_r <= ST_DRAIN;
            drain_r <= DRAIN_LAST;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          ovf_r  <= ovf_next_s;
`ifdef LFSR_OVF_SAT_EN
          flag_r <= flag_next_s;
`endif
          if (Abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            clr_n_r <= 1'b0;
          end else begin
            timer_r <= timer_r - WIN_ONE;
            if (timer_r == WIN_ONE) begin
              state_r <= ST_DRAIN;
              drain_r <= DRAIN_LAST;
            end else begin
              state_r <= ST_RUN;
            end
          end
        end
        ST_DRAIN: begin
          ovf_r  <= ovf_next_s;
`ifdef LFSR_OVF_SAT_EN
          flag_r <= flag_next_s;
`endif
          if (Abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            clr_n_r <= 1'b0;
          end else if (drain_r == DRAIN_ZERO) begin
            // Capture includes a wrap pulse arriving on this final drain cycle.
            state_r          <= ST_DONE;
            res.Res_Valid    <= 1'b1;
            res.Res_Ovf      <= ovf_next_s;
            res.Res_Lfsr     <= Ctr_Q;
            res.Res_Ovf_Flag <= flag_next_s;
          end else begin
            drain_r <= drain_r - DRAIN_ONE;
          end
        end
        ST_DONE: begin
          if (res.Res_Ready) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            res.Res_Valid <= 1'b0;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          busy_r        <= 1'b0;
          res.Res_Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
